// File: rtl/decode_stage.sv
// RV32I decode: registers decoded fields/PC, drives RF read addresses aligned to the 1-cycle RF read.
// Latency 1 cycle; o_ready drops while a held instruction is stalled downstream or the RF write enable is high.
module decode_stage #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH_P-1:0] i_instr,
    input  logic [DATA_WIDTH_P-1:0] i_pc,
    input  logic                    i_wb_wr_enable,
    output logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_a,
    output logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH_P-1:0] o_pc,
    output logic [6:0]              o_opcode,
    output logic [ADDR_WIDTH_P-1:0] o_rd,
    output logic [2:0]              o_funct3,
    output logic                    o_funct7b5,
    output logic [DATA_WIDTH_P-1:0] o_imm,
    output logic                    o_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {EMPTY, FULL, REFRESH} state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    state_t      state;
    logic        valid_q;
    logic [31:0] pc_q;
    dec_t        dec_q;
    dec_t        dec;
    logic        accept;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'b0};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Every recognised opcode ends in 2'b11, so the default arm also catches bad low bits.
    always_comb begin
        dec          = '0;
        dec.opcode   = i_instr[6:0];
        dec.funct3   = i_instr[14:12];
        dec.funct7b5 = i_instr[30];
        case (i_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                dec.rd  = i_instr[11:7];
                dec.imm = imm_u;
            end
            OP_JAL: begin
                dec.rd  = i_instr[11:7];
                dec.imm = imm_j;
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
                dec.rs1 = i_instr[19:15];
                dec.rd  = i_instr[11:7];
                dec.imm = imm_i;
            end
            OP_FENCE: begin
                dec.rd  = i_instr[11:7];
                dec.imm = imm_i;
            end
            OP_BRANCH: begin
                dec.rs1 = i_instr[19:15];
                dec.rs2 = i_instr[24:20];
                dec.imm = imm_b;
            end
            OP_STORE: begin
                dec.rs1 = i_instr[19:15];
                dec.rs2 = i_instr[24:20];
                dec.imm = imm_s;
            end
            OP_OP: begin
                dec.rs1 = i_instr[19:15];
                dec.rs2 = i_instr[24:20];
                dec.rd  = i_instr[11:7];
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // The RF suppresses reads in any cycle it is written, so nothing is accepted then.
    assign o_ready = !reset && !i_wb_wr_enable &&
                     (state == EMPTY || (state == FULL && i_ready));
    assign accept  = i_valid && o_ready;

    // Held addresses keep being presented so a re-read after a write returns fresh data.
    always_comb begin
        o_rf_rd_addr_a = '0;
        o_rf_rd_addr_b = '0;
        if (accept) begin
            o_rf_rd_addr_a = dec.rs1;
            o_rf_rd_addr_b = dec.rs2;
        end else if (state != EMPTY) begin
            o_rf_rd_addr_a = dec_q.rs1;
            o_rf_rd_addr_b = dec_q.rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            pc_q    <= '0;
            dec_q   <= '0;
        end else if (i_flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        valid_q <= 1'b1;
                        pc_q    <= i_pc;
                        dec_q   <= dec;
                    end
                end
                FULL: begin
                    if (accept) begin
                        pc_q  <= i_pc;
                        dec_q <= dec;
                    end else if (i_ready) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end else if (i_wb_wr_enable) begin
                        state   <= REFRESH;
                        valid_q <= 1'b0;
                    end
                end
                REFRESH: begin
                    if (!i_wb_wr_enable) begin
                        state   <= FULL;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid    = valid_q;
    assign o_pc       = pc_q;
    assign o_opcode   = dec_q.opcode;
    assign o_rd       = dec_q.rd;
    assign o_funct3   = dec_q.funct3;
    assign o_funct7b5 = dec_q.funct7b5;
    assign o_imm      = dec_q.imm;
    assign o_illegal  = dec_q.illegal;

endmodule
